// File: rtl/count_uart_tx.sv
// Serializes a BITS-wide count word as NBYTES back-to-back 8N1 UART frames, LSB byte first.
// The bit period is (divisor+1) clk cycles, captured when the word is accepted.
module count_uart_tx #(
  parameter int BITS        = 32,
  parameter int DIV_W       = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BITS-1:0]        in_data,
  output logic                   in_ready,
  input  logic [DIV_W-1:0]       divisor,
  output logic                   tx,
  output logic                   busy,
  output logic                   word_done,
  output logic [FRAME_CNT_W-1:0] frames_sent
);

  localparam int NBYTES = BITS / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [BITS-1:0]        shift_q, shift_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]      byte_idx_q, byte_idx_d;
  logic                   tx_q, tx_d;
  logic                   word_done_q, word_done_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;
  logic                   bit_end;

  assign in_ready    = (state_q == IDLE) && !reset;
  assign busy        = (state_q != IDLE);
  assign tx          = tx_q;
  assign word_done   = word_done_q;
  assign frames_sent = frames_q;
  assign bit_end     = (baud_q == '0);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    tx_d        = tx_q;
    word_done_d = 1'b0;
    frames_d    = frames_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid && in_ready) begin
          // tx is registered, so driving it low here puts the start bit on the accept edge.
          shift_d    = in_data;
          div_d      = divisor;
          baud_d     = divisor;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = div_q;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          // Shifting after every data bit leaves the next byte sitting in shift_q[7:0].
          baud_d  = div_q;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          frames_d = frames_q + FRAME_CNT_W'(1);
          if (byte_idx_q == LAST_BYTE) begin
            baud_d      = '0;
            tx_d        = 1'b1;
            word_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            baud_d     = div_q;
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            tx_d       = 1'b0;
            state_d    = START;
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      div_q       <= '0;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      tx_q        <= 1'b1;
      word_done_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
      word_done_q <= word_done_d;
      frames_q    <= frames_d;
    end
  end

endmodule
